i2s_eth_framer: RTL and testbench
=================================

Name: i2s_eth_framer

Overview:
Sits directly downstream of i2s_in_fifo and upstream of the MAC TX AXI-stream in fpga_core. It wraps each audio packet from i2s_in_fifo (8-bit AXIS, tlast per packet) in an Ethernet II frame: 14-byte header, then the payload, then zero padding up to the 46-byte minimum. Over-length packets are truncated and counted. The destination is the FPGA selected by register; the source is this FPGA's index.

Parameters:
ETHERTYPE, 16'h88B5, EtherType placed in header bytes 12-13.
MAC_OUI, 24'h020000, upper 3 bytes of both MAC addresses (locally administered).
MIN_PAYLOAD, 46, minimum payload bytes; shorter packets are zero-padded.
MAX_PAYLOAD, 1500, maximum payload bytes; longer packets are truncated.

Ports:
clk  input  1  125 MHz system clock (clk_int domain)
rst  input  1  synchronous reset, active high
fpga_index  input  4  own index; source MAC = {MAC_OUI, 20'h0, fpga_index}
dst_fpga_index  input  4  destination index; 4'hF selects broadcast FF:FF:FF:FF:FF:FF, otherwise {MAC_OUI, 20'h0, idx}
s_axis_tvalid  input  1  audio packet byte valid (from i2s_in_fifo)
s_axis_tdata  input  8  audio packet byte
s_axis_tlast  input  1  last byte of audio packet
s_axis_tready  output  1  accept strobe to i2s_in_fifo
m_axis_tvalid  output  1  frame byte valid (to MAC TX)
m_axis_tdata  output  8  frame byte
m_axis_tlast  output  1  last byte of frame
m_axis_tready  input  1  MAC TX ready
frame_count  output  32  frames completed (m_axis tlast handshakes), saturating
trunc_count  output  16  packets truncated at MAX_PAYLOAD, saturating
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE. All counters = 0. s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0.
- Reset mid-frame aborts immediately with no tlast emitted. The downstream MAC drops the runt. The next frame restarts with a header.
- A handshake occurs when valid && ready on the same edge. All counts advance only on handshakes.
- States: IDLE, HEADER, PAYLOAD, PAD, DROP.
- IDLE: s_axis_tready=0, m_axis_tvalid=0. When s_axis_tvalid=1, latch fpga_index and dst_fpga_index (held for the whole frame), clear hdr_cnt and pay_cnt, and go to HEADER.
  - The first header byte is valid the cycle after s_axis_tvalid is sampled.
  - The input byte is not consumed in IDLE.
- HEADER: m_axis_tvalid=1 (registered, stable until handshake); s_axis_tready=0.
  - Byte hdr_cnt 0-5 = destination MAC, MSB first.
  - Bytes 6-11 = source MAC, MSB first.
  - Bytes 12-13 = ETHERTYPE, MSB first.
  - On the byte-13 handshake, go to PAYLOAD.
- PAYLOAD: combinational pass-through. m_axis_tvalid=s_axis_tvalid, m_axis_tdata=s_axis_tdata, s_axis_tready=m_axis_tready. pay_cnt (11 bits) increments per handshake.
  - s_axis_tlast with pay_cnt+1 >= MIN_PAYLOAD: m_axis_tlast=1; on handshake go to IDLE and increment frame_count.
  - s_axis_tlast with pay_cnt+1 < MIN_PAYLOAD: m_axis_tlast=0; on handshake go to PAD.
  - pay_cnt+1 == MAX_PAYLOAD without s_axis_tlast: m_axis_tlast=1; on handshake increment frame_count and trunc_count, then go to DROP.
  - pay_cnt+1 == MAX_PAYLOAD with s_axis_tlast: normal end, no truncation.
- PAD: m_axis_tvalid=1, m_axis_tdata=8'h00, s_axis_tready=0. pay_cnt increments per handshake.
  - m_axis_tlast=1 when pay_cnt == MIN_PAYLOAD-1; on that handshake go to IDLE and increment frame_count.
- DROP: s_axis_tready=1, m_axis_tvalid=0. Discard input until the s_axis_tlast handshake, then go to IDLE.
- Back-to-back packets: IDLE always costs ≥1 cycle between frames. The header is never merged with the previous frame.
- Counters saturate at all-ones; no wrap.
- fpga_index and dst_fpga_index changes mid-frame have no effect until the next IDLE exit.
- m_axis_tvalid is never deasserted before a handshake in HEADER or PAD; in PAYLOAD it mirrors the source.

Test Plan:
- fpga_index=2, dst=5, 64-byte packet 0x00..0x3F, tready=1 → 78 bytes: 02 00 00 00 00 05 02 00 00 00 00 02 88 B5, then 00..3F; tlast on byte 78; frame_count=1.
- dst=4'hF, 10-byte packet → header starts FF×6; payload 10 bytes, then 36 bytes 00; tlast on total byte 60; trunc_count=0.
- 1600-byte packet → 1514 bytes out, tlast on byte 1514; remaining 100 input bytes consumed with m_axis_tvalid=0; trunc_count=1, frame_count=1.
- Exactly 46-byte and exactly 1500-byte packets → no pad and no truncation; output 60 and 1514 bytes; trunc_count=0.
- Random m_axis_tready (50%) and random s_axis_tvalid gaps on 3 back-to-back packets → byte streams identical to the tready=1 case; no data/valid change while stalled; frame_count=3.
- rst pulsed during HEADER byte 7, then a new 20-byte packet → outputs idle the cycle after rst; fresh 14-byte header then 20+26 bytes; frame_count=1.

Source files
------------

// File: rtl/i2s_eth_framer.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_eth_framer
//  Description : Wraps each audio packet from the I2S input FIFO in an
//                Ethernet II frame (dst MAC, src MAC, EtherType, payload,
//                zero padding to the minimum payload; over-length packets
//                are truncated and the remainder is discarded).
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_eth_framer #(
   parameter logic [15:0] ETHERTYPE   = 16'h88B5,
   parameter logic [23:0] MAC_OUI     = 24'h020000,
   parameter int          MIN_PAYLOAD = 46,
   parameter int          MAX_PAYLOAD = 1500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  fpga_index,
   input  logic [3:0]  dst_fpga_index,
   input  logic        s_axis_tvalid,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   output logic        m_axis_tvalid,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   output logic [31:0] frame_count,
   output logic [15:0] trunc_count,
   output logic        busy
);

   localparam logic [10:0] c_MIN_PAY    = MIN_PAYLOAD[10:0];
   localparam logic [10:0] c_MIN_PAY_M1 = c_MIN_PAY - 11'd1;
   localparam logic [10:0] c_MAX_PAY    = MAX_PAYLOAD[10:0];
   localparam logic [3:0]  c_HDR_LAST   = 4'd13;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HEADER  = 3'd1,
      S_PAYLOAD = 3'd2,
      S_PAD     = 3'd3,
      S_DROP    = 3'd4
   } state_t;

   state_t      r_state;
   logic [3:0]  r_hdr_cnt;
   logic [10:0] r_pay_cnt;
   logic [3:0]  r_src_idx;
   logic [3:0]  r_dst_idx;
   logic        r_m_tvalid;
   logic [7:0]  r_m_tdata;
   logic        r_m_tlast;
   logic [31:0] r_frame_count;
   logic [15:0] r_trunc_count;

   logic [10:0] w_pay_next;
   logic        w_in_payload;
   logic        w_pay_last;
   logic        w_pay_hs;
   logic        w_frame_done;
   logic        w_trunc;

   // Header byte n of the 14-byte Ethernet II header, MSB first.
   function automatic logic [7:0] hdr_byte(input logic [3:0] n,
                                           input logic [3:0] src,
                                           input logic [3:0] dst);
      logic [47:0]  dmac;
      logic [47:0]  smac;
      logic [111:0] hdr;
      dmac = (dst == 4'hF) ? 48'hFFFF_FFFF_FFFF : {MAC_OUI, 20'h0, dst};
      smac = {MAC_OUI, 20'h0, src};
      hdr  = {dmac, smac, ETHERTYPE} << {n, 3'b000};
      return hdr[111:104];
   endfunction

   assign w_pay_next   = r_pay_cnt + 11'd1;
   assign w_in_payload = (r_state == S_PAYLOAD);
   assign w_pay_hs     = w_in_payload && s_axis_tvalid && m_axis_tready;
   // A packet end closes the frame only once the minimum length is reached;
   // without tlast, the maximum length forces the frame to close.
   assign w_pay_last   = s_axis_tlast ? (w_pay_next >= c_MIN_PAY)
                                      : (w_pay_next == c_MAX_PAY);

   // Payload is a combinational pass-through; every other state drives
   // the registered output stage.
   assign m_axis_tvalid = w_in_payload ? s_axis_tvalid : r_m_tvalid;
   assign m_axis_tdata  = w_in_payload ? s_axis_tdata  : r_m_tdata;
   assign m_axis_tlast  = w_in_payload ? w_pay_last    : r_m_tlast;
   assign s_axis_tready = w_in_payload ? m_axis_tready : (r_state == S_DROP);
   assign busy          = (r_state != S_IDLE);

   assign w_frame_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
   assign w_trunc      = w_pay_hs && !s_axis_tlast && (w_pay_next == c_MAX_PAY);

   assign frame_count = r_frame_count;
   assign trunc_count = r_trunc_count;

   // Framing state machine with registered header/pad output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_hdr_cnt  <= 4'd0;
         r_pay_cnt  <= 11'd0;
         r_src_idx  <= 4'd0;
         r_dst_idx  <= 4'd0;
         r_m_tvalid <= 1'b0;
         r_m_tdata  <= 8'h00;
         r_m_tlast  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (s_axis_tvalid) begin
                  r_src_idx  <= fpga_index;
                  r_dst_idx  <= dst_fpga_index;
                  r_hdr_cnt  <= 4'd0;
                  r_pay_cnt  <= 11'd0;
                  r_m_tvalid <= 1'b1;
                  r_m_tdata  <= hdr_byte(4'd0, fpga_index, dst_fpga_index);
                  r_m_tlast  <= 1'b0;
                  r_state    <= S_HEADER;
               end
            end
            S_HEADER: begin
               if (m_axis_tready) begin
                  if (r_hdr_cnt == c_HDR_LAST) begin
                     r_m_tvalid <= 1'b0;
                     r_m_tdata  <= 8'h00;
                     r_state    <= S_PAYLOAD;
                  end else begin
                     r_hdr_cnt <= r_hdr_cnt + 4'd1;
                     r_m_tdata <= hdr_byte(r_hdr_cnt + 4'd1, r_src_idx, r_dst_idx);
                  end
               end
            end
            S_PAYLOAD: begin
               if (w_pay_hs) begin
                  r_pay_cnt <= w_pay_next;
                  if (s_axis_tlast) begin
                     if (w_pay_next >= c_MIN_PAY) begin
                        r_state <= S_IDLE;
                     end else begin
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= 8'h00;
                        r_m_tlast  <= (w_pay_next == c_MIN_PAY_M1);
                        r_state    <= S_PAD;
                     end
                  end else if (w_pay_next == c_MAX_PAY) begin
                     r_state <= S_DROP;
                  end
               end
            end
            S_PAD: begin
               if (m_axis_tready) begin
                  r_pay_cnt <= w_pay_next;
                  if (r_pay_cnt == c_MIN_PAY_M1) begin
                     r_m_tvalid <= 1'b0;
                     r_m_tlast  <= 1'b0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_m_tlast <= (w_pay_next == c_MIN_PAY_M1);
                  end
               end
            end
            S_DROP: begin
               if (s_axis_tvalid && s_axis_tlast) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Saturating frame and truncation counters, advanced on handshakes only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_count <= 32'd0;
         r_trunc_count <= 16'd0;
      end else begin
         if (w_frame_done && (r_frame_count != 32'hFFFF_FFFF)) begin
            r_frame_count <= r_frame_count + 32'd1;
         end
         if (w_trunc && (r_trunc_count != 16'hFFFF)) begin
            r_trunc_count <= r_trunc_count + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2s_eth_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_i2s_eth_framer
//  Description : Self-checking bench for i2s_eth_framer; a frame-level
//                reference model builds each expected output byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_eth_framer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  fpga_index = 4'd0;
   logic [3:0]  dst_fpga_index = 4'd0;
   logic        s_axis_tvalid = 1'b0;
   logic [7:0]  s_axis_tdata = 8'h00;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tready;
   logic        m_axis_tvalid;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tlast;
   logic        m_axis_tready = 1'b1;
   logic [31:0] frame_count;
   logic [15:0] trunc_count;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0]  exp_q[$];       // {tlast, tdata}
   int          len_q[$];       // observed frame lengths
   logic [7:0]  cap[0:1599];    // bytes of the frame currently being observed
   logic [7:0]  pkts[0:3][0:1599];
   int          cur_len = 0;
   int          exp_frames = 0;
   int          exp_trunc = 0;
   bit          rnd_ready = 1'b0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   logic        prev_last = 1'b0;

   i2s_eth_framer dut (
      .clk            (clk),
      .rst            (rst),
      .fpga_index     (fpga_index),
      .dst_fpga_index (dst_fpga_index),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tlast   (s_axis_tlast),
      .s_axis_tready  (s_axis_tready),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tready  (m_axis_tready),
      .frame_count    (frame_count),
      .trunc_count    (trunc_count),
      .busy           (busy)
   );

   always #4 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Downstream ready: always on, or a fair coin per cycle.
   always @(posedge clk) begin
      #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor: every handshake is compared with the model queue, and
   // a stalled beat must hold valid, data and last.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         cur_len    = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", {31'd0, m_axis_tvalid}, 32'd1);
            chk("stall_data",  {24'd0, m_axis_tdata}, {24'd0, prev_data});
            chk("stall_last",  {31'd0, m_axis_tlast}, {31'd0, prev_last});
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               chk("extra_byte", 32'(exp_q.size()), 32'd1);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               chk("tdata", {24'd0, m_axis_tdata}, {24'd0, e[7:0]});
               chk("tlast", {31'd0, m_axis_tlast}, {31'd0, e[8]});
            end
            if (cur_len < 1600) cap[cur_len] = m_axis_tdata;
            cur_len++;
            if (m_axis_tlast) begin
               len_q.push_back(cur_len);
               cur_len = 0;
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
      end
   end

   // Reference: 14-byte header for a given source/destination index.
   task automatic model_header(input logic [3:0] src, input logic [3:0] dst);
      logic [47:0] dm;
      logic [47:0] sm;
      dm = (dst == 4'hF) ? 48'hFFFF_FFFF_FFFF : {24'h020000, 20'h0, dst};
      sm = {24'h020000, 20'h0, src};
      for (int b = 0; b < 6; b++) begin
         exp_q.push_back({1'b0, dm[47:40]});
         dm = dm << 8;
      end
      for (int b = 0; b < 6; b++) begin
         exp_q.push_back({1'b0, sm[47:40]});
         sm = sm << 8;
      end
      exp_q.push_back({1'b0, 8'h88});
      exp_q.push_back({1'b0, 8'hB5});
   endtask

   // Reference: complete frame for packet p of length len.
   task automatic model_frame(input int p, input int len, input logic [3:0] src,
                              input logic [3:0] dst);
      int n;
      int total;
      model_header(src, dst);
      n     = (len > 1500) ? 1500 : len;
      total = (n < 46) ? 46 : n;
      for (int i = 0; i < total; i++) begin
         logic [7:0] d;
         d = (i < n) ? pkts[p][i] : 8'h00;
         exp_q.push_back({(i == total - 1), d});
      end
      exp_frames++;
      if (len > 1500) exp_trunc++;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      len_q.delete();
      exp_frames = 0;
      exp_trunc  = 0;
      @(negedge clk);
      chk("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
      chk("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("rst_m_tlast",  {31'd0, m_axis_tlast}, 32'd0);
      chk("rst_m_tdata",  {24'd0, m_axis_tdata}, 32'd0);
      chk("rst_busy",     {31'd0, busy}, 32'd0);
      chk("rst_frames",   frame_count, 32'd0);
      chk("rst_trunc",    {16'd0, trunc_count}, 32'd0);
   endtask

   // Drive packet p onto the slave port, optionally with random gaps.
   task automatic send_pkt(input int p, input int len, input bit gaps);
      @(posedge clk); #1;
      for (int i = 0; i < len; i++) begin
         bit hs;
         int k;
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk); #1;
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = pkts[p][i];
         s_axis_tlast  = (i == len - 1);
         hs = 1'b0;
         k  = 0;
         while (!hs && k < 20000) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk); #1;
            k++;
         end
         if (!hs) begin
            chk("src_timeout", {31'd0, hs}, 32'd1);
            break;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) break;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      chk("busy_end", {31'd0, busy}, 32'd0);
      chk("frames", frame_count, 32'(exp_frames));
      chk("truncs", {16'd0, trunc_count}, 32'(exp_trunc));
   endtask

   function automatic int next_len();
      return (len_q.size() > 0) ? len_q.pop_front() : -1;
   endfunction

   initial begin
      #(700_000);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lens[3];

      // Test 1: 64-byte ramp, idx 2 -> 5.
      do_reset();
      for (int i = 0; i < 64; i++) pkts[0][i] = 8'(i);
      fpga_index = 4'd2; dst_fpga_index = 4'd5;
      model_frame(0, 64, 4'd2, 4'd5);
      send_pkt(0, 64, 1'b0);
      wait_idle();
      chk("t1_len", 32'(next_len()), 32'd78);
      chk("t1_b5",  {24'd0, cap[5]},  32'h05);
      chk("t1_b11", {24'd0, cap[11]}, 32'h02);
      chk("t1_b12", {24'd0, cap[12]}, 32'h88);
      chk("t1_b13", {24'd0, cap[13]}, 32'hB5);
      chk("t1_b77", {24'd0, cap[77]}, 32'h3F);
      chk("t1_frames", frame_count, 32'd1);

      // Test 2: broadcast, 10-byte packet padded to 46.
      do_reset();
      for (int i = 0; i < 10; i++) pkts[0][i] = 8'(i + 1);
      dst_fpga_index = 4'hF;
      model_frame(0, 10, 4'd2, 4'hF);
      send_pkt(0, 10, 1'b0);
      wait_idle();
      chk("t2_len", 32'(next_len()), 32'd60);
      chk("t2_b0",  {24'd0, cap[0]},  32'hFF);
      chk("t2_b23", {24'd0, cap[23]}, 32'h0A);
      chk("t2_b24", {24'd0, cap[24]}, 32'h00);
      chk("t2_trunc", {16'd0, trunc_count}, 32'd0);

      // Test 3: 1600-byte packet truncated at 1500.
      do_reset();
      for (int i = 0; i < 1600; i++) pkts[0][i] = 8'($urandom);
      dst_fpga_index = 4'd1;
      model_frame(0, 1600, 4'd2, 4'd1);
      send_pkt(0, 1600, 1'b0);
      wait_idle();
      chk("t3_len", 32'(next_len()), 32'd1514);
      chk("t3_trunc", {16'd0, trunc_count}, 32'd1);
      chk("t3_frames", frame_count, 32'd1);

      // Test 4: exactly 46 and exactly 1500 bytes.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         pkts[0][i] = 8'($urandom);
         pkts[1][i] = 8'($urandom);
      end
      model_frame(0, 46, 4'd2, 4'd1);
      model_frame(1, 1500, 4'd2, 4'd1);
      send_pkt(0, 46, 1'b0);
      send_pkt(1, 1500, 1'b0);
      wait_idle();
      chk("t4_len46",   32'(next_len()), 32'd60);
      chk("t4_len1500", 32'(next_len()), 32'd1514);
      chk("t4_trunc", {16'd0, trunc_count}, 32'd0);

      // Test 5: three back-to-back random packets under random backpressure.
      do_reset();
      rnd_ready = 1'b1;
      fpga_index = 4'(  $urandom_range(0, 14));
      dst_fpga_index = 4'($urandom_range(0, 15));
      lens[0] = 30; lens[1] = 100; lens[2] = $urandom_range(1, 200);
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < lens[p]; i++) pkts[p][i] = 8'($urandom);
         model_frame(p, lens[p], fpga_index, dst_fpga_index);
      end
      for (int p = 0; p < 3; p++) send_pkt(p, lens[p], 1'b1);
      wait_idle();
      chk("t5_frames", frame_count, 32'd3);
      chk("t5_len0", 32'(next_len()), 32'd60);
      chk("t5_len1", 32'(next_len()), 32'd114);
      rnd_ready = 1'b0;

      // Test 6: reset during header byte 7, then a 20-byte packet.
      do_reset();
      fpga_index = 4'd3; dst_fpga_index = 4'd7;
      model_header(4'd3, 4'd7);
      @(posedge clk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'hAA;
      s_axis_tlast  = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         if (cur_len >= 7) break;
      end
      #1;
      rst = 1'b1;
      s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("t6_idle_valid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("t6_idle_busy",  {31'd0, busy}, 32'd0);
      chk("t6_idle_last",  {31'd0, m_axis_tlast}, 32'd0);
      chk("t6_runt_frames", frame_count, 32'd0);
      chk("t6_runt_nolast", 32'(len_q.size()), 32'd0);
      for (int i = 0; i < 20; i++) pkts[0][i] = 8'(8'h40 + i);
      model_frame(0, 20, 4'd3, 4'd7);
      send_pkt(0, 20, 1'b0);
      wait_idle();
      chk("t6_len", 32'(next_len()), 32'd60);
      chk("t6_frames", frame_count, 32'd1);

      // Test 7: random lengths with gaps and backpressure.
      do_reset();
      rnd_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         int len;
         len = $urandom_range(1, 400);
         fpga_index = 4'($urandom);
         dst_fpga_index = 4'($urandom);
         for (int i = 0; i < len; i++) pkts[0][i] = 8'($urandom);
         model_frame(0, len, fpga_index, dst_fpga_index);
         send_pkt(0, len, 1'b1);
      end
      wait_idle();
      rnd_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
